// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//   Packs decoded instruction descriptors (class, register indices, funct
//   fields, immediate) into RV32I words and streams them into instruction
//   memory at sequential word addresses, one write per accepted descriptor.
//
//   Optional build macro: INST_ENC_RANGE_CHECK_EN
//     When defined, descriptors whose immediate does not fit the target
//     format are rejected as illegal (counted in err_cnt, not written).
//     When undefined, immediates are silently truncated to the encoded slices.
module inst_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_class,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   word_cnt
);

    // descriptor classes
    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_IALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_LUI    = 3'd5;
    localparam logic [2:0] CLS_JAL    = 3'd6;
    localparam logic [2:0] CLS_ILL    = 3'd7;

    // RV32I major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [ADDR_W-1:0] BASE_W     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;        // next word address to be written
    logic              room;       // session still below DEPTH words
    logic              last_slot;  // next legal word fills the session
    logic              accept;     // descriptor handshake this cycle
    logic              range_bad;  // immediate does not fit its format
    logic              legal;      // descriptor produces a memory write
    logic              shift_op;   // I-ALU shift: funct7 shares [31:25]
    logic [31:0]       enc;        // combinationally encoded word

    assign room      = (word_cnt < DEPTH_W);
    assign last_slot = (word_cnt == DEPTH_LAST);
    assign accept    = (state == LOAD) && room && in_valid;
    assign legal     = (op_class != CLS_ILL) && !range_bad;
    assign shift_op  = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef INST_ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm;

    // Flag immediates that would lose information when sliced into the word
    always_comb begin
        range_bad = 1'b0;
        case (op_class)
            CLS_IALU, CLS_LOAD, CLS_STORE:
                range_bad = (simm < -2048) || (simm > 2047);
            CLS_BRANCH:
                range_bad = (simm < -4096) || (simm > 4094) || imm[0];
            CLS_JAL:
                range_bad = (simm < -1048576) || (simm > 1048574) || imm[0];
            CLS_LUI:
                range_bad = (imm[11:0] != 12'd0);
            default:
                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // Pack the descriptor into its RV32I format; illegal class encodes to 0
    always_comb begin
        enc = 32'd0;
        case (op_class)
            CLS_R:
                enc = {funct7, rs2, rs1, funct3, rd, OPC_R};
            CLS_IALU:
                if (shift_op) enc = {funct7, imm[4:0], rs1, funct3, rd, OPC_IALU};
                else          enc = {imm[11:0], rs1, funct3, rd, OPC_IALU};
            CLS_LOAD:
                enc = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_STORE:
                enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_BRANCH:
                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            CLS_LUI:
                enc = {imm[31:12], rd, OPC_LUI};
            CLS_JAL:
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default:
                enc = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Session sequencing: open on start, close on in_last or when DEPTH fills
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = room;
                if (accept && (in_last || (legal && last_slot))) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write port, address pointer and session counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= BASE_W;
            imem_addr  <= BASE_W;
            imem_wdata <= 32'd0;
            imem_we    <= 1'b0;
            word_cnt   <= '0;
            err_cnt    <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if ((state == IDLE) && start) begin
                ptr       <= BASE_W;
                imem_addr <= BASE_W;
                word_cnt  <= '0;
                err_cnt   <= 8'd0;
                overflow  <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc;
                    ptr        <= ptr + PTR_ONE;     // wraps modulo 2^ADDR_W
                    word_cnt   <= word_cnt + CNT_ONE;
                    if (last_slot && !in_last) overflow <= 1'b1;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: a session-level reference model predicts the
// outputs every cycle, and hand-assembled RV32I words pin the results.
module tb_inst_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int BASE   = 0;
    localparam int DEPTH  = 4;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last  = 1'b0;
    logic [2:0]        op_class = 3'd0;
    logic [2:0]        funct3   = 3'd0;
    logic [6:0]        funct7   = 7'd0;
    logic [4:0]        rd       = 5'd0;
    logic [4:0]        rs1      = 5'd0;
    logic [4:0]        rs2      = 5'd0;
    logic [31:0]       imm      = 32'd0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              overflow;
    logic [7:0]        err_cnt;
    logic [ADDR_W:0]   word_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .op_class(op_class),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .overflow(overflow),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] enc_m(input logic [2:0] c, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im);
        logic [31:0] w;
        logic [31:0] regs;
        regs = (32'(s1) << 15) | (32'(f3) << 12);
        case (c)
            3'd0: w = (32'(f7) << 25) | (32'(s2) << 20) | regs | (32'(d) << 7) | 32'h33;
            3'd1: if (f3 == 3'd1 || f3 == 3'd5)
                      w = (32'(f7) << 25) | ((im & 32'h1F) << 20) | regs | (32'(d) << 7) | 32'h13;
                  else
                      w = ((im & 32'hFFF) << 20) | regs | (32'(d) << 7) | 32'h13;
            3'd2: w = ((im & 32'hFFF) << 20) | regs | (32'(d) << 7) | 32'h03;
            3'd3: w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | regs
                      | ((im & 32'h1F) << 7) | 32'h23;
            3'd4: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                      | (32'(s2) << 20) | regs | (((im >> 1) & 32'hF) << 8)
                      | (((im >> 11) & 32'h1) << 7) | 32'h63;
            3'd5: w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h37;
            3'd6: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (32'(d) << 7) | 32'h6F;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit legal_m(input logic [2:0] c, input logic [31:0] im);
        int s;
        s = im;
        if (c == 3'd7) return 1'b0;
`ifdef INST_ENC_RANGE_CHECK_EN
        if ((c == 3'd1 || c == 3'd2 || c == 3'd3) && (s < -2048 || s > 2047)) return 1'b0;
        if (c == 3'd4 && (s < -4096 || s > 4094 || im[0])) return 1'b0;
        if (c == 3'd6 && (s < -(1 << 20) || s > (1 << 20) - 2 || im[0])) return 1'b0;
        if (c == 3'd5 && (im & 32'hFFF) != 0) return 1'b0;
`endif
        return (s == s);
    endfunction

    bit          m_init  = 1'b0;
    int          m_phase = 0;      // 0 idle, 1 loading, 2 done pulse
    int          m_cnt   = 0;
    int          m_err   = 0;
    bit          m_ovf   = 1'b0;
    int          m_ptr   = BASE;
    bit          m_we    = 1'b0;
    int          m_waddr = 0;
    logic [31:0] m_wdata = 32'd0;
    int          cyc     = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_init = 1'b1; m_phase = 0; m_cnt = 0; m_err = 0;
            m_ovf = 1'b0; m_ptr = BASE; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            case (m_phase)
                0: if (start) begin
                       m_phase = 1; m_cnt = 0; m_err = 0; m_ovf = 1'b0; m_ptr = BASE;
                   end
                1: if (in_valid && m_cnt < DEPTH) begin
                       if (legal_m(op_class, imm)) begin
                           m_we    = 1'b1;
                           m_waddr = m_ptr;
                           m_wdata = enc_m(op_class, funct3, funct7, rd, rs1, rs2, imm);
                           m_ptr   = (m_ptr + 1) % (1 << ADDR_W);
                           m_cnt++;
                           if (!in_last && m_cnt == DEPTH) begin
                               m_ovf = 1'b1; m_phase = 2;
                           end
                       end else if (m_err < 255) begin
                           m_err++;
                       end
                       if (in_last) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    logic [31:0] wlog_d[$];
    int          wlog_a[$];
    int          wlog_c[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", in_ready, (m_phase == 1 && m_cnt < DEPTH));
            chk("imem_we",  imem_we,  m_we);
            chk("done",     done,     (m_phase == 2));
            chk("overflow", overflow, m_ovf);
            chk("err_cnt",  err_cnt,  m_err);
            chk("word_cnt", word_cnt, m_cnt);
            if (m_we) begin
                chk("imem_addr",  imem_addr,  m_waddr);
                chk("imem_wdata", imem_wdata, m_wdata);
            end
        end
        if (imem_we === 1'b1) begin
            wlog_d.push_back(imem_wdata);
            wlog_a.push_back(int'(imem_addr));
            wlog_c.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [31:0] log_d(input int i);
        return (i < wlog_d.size()) ? wlog_d[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] log_a(input int i);
        return (i < wlog_a.size()) ? 32'(wlog_a[i]) : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] log_gap(input int i);
        return (i + 1 < wlog_c.size()) ? 32'(wlog_c[i+1] - wlog_c[i]) : 32'hxxxxxxxx;
    endfunction

    // ---------------- stimulus ----------------
    task automatic open_session();
        wlog_d.delete(); wlog_a.delete(); wlog_c.delete(); done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_desc(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [31:0] im, input logic last);
        op_class = c; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
        imm = im; in_last = last;
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input logic last);
        bit took;
        took = 1'b0;
        set_desc(c, f3, f7, d, s1, s2, im, last);
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            took = (in_ready === 1'b1);
            @(negedge clk);
            if (took) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("handshake", took, 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we",    imem_we,    1'b0);
        chk("rst_ready", in_ready,   1'b0);
        chk("rst_done",  done,       1'b0);
        chk("rst_ovf",   overflow,   1'b0);
        chk("rst_addr",  imem_addr,  BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_err",   err_cnt,    8'd0);
        chk("rst_wcnt",  word_cnt,   0);
        rst_n = 1'b1;
        @(negedge clk);

        // single R-type add, last descriptor
        open_session();
        send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        settle();
        chk("t1_nwr",  wlog_d.size(), 1);
        chk("t1_addr", log_a(0), 0);
        chk("t1_data", log_d(0), 32'h002081B3);
        chk("t1_done", done_cnt, 1);
        chk("t1_wcnt", word_cnt, 1);

        // back-to-back addi / lw / sw
        open_session();
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0);
        send(3'd2, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0);
        send(3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1);
        settle();
        chk("t2_nwr",   wlog_d.size(), 3);
        chk("t2_d0",    log_d(0), 32'h00500093);
        chk("t2_d1",    log_d(1), 32'hFFC12203);
        chk("t2_d2",    log_d(2), 32'h0020A423);
        chk("t2_a2",    log_a(2), 2);
        chk("t2_gap01", log_gap(0), 1);
        chk("t2_gap12", log_gap(1), 1);
        chk("t2_done",  done_cnt, 1);

        // lui / jal / beq
        open_session();
        send(3'd5, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
        send(3'd6, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,        1'b0);
        send(3'd4, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1);
        settle();
        chk("t3_lui", log_d(0), 32'h123452B7);
        chk("t3_jal", log_d(1), 32'h008000EF);
        chk("t3_beq", log_d(2), 32'hFE000EE3);
        chk("t3_m_sh", enc_m(3'd1, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd7), 32'h40725193);

        // illegal descriptor between two legal ones
        open_session();
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        send(3'd7, 3'd0, 7'd0, 5'd9, 5'd9, 5'd9, 32'd1, 1'b0);
        send(3'd1, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1);
        settle();
        chk("t4_nwr", wlog_d.size(), 2);
        chk("t4_a0",  log_a(0), 0);
        chk("t4_a1",  log_a(1), 1);
        chk("t4_d1",  log_d(1), 32'h00200113);
        chk("t4_err", err_cnt, 8'd1);

        // DEPTH reached without in_last
        open_session();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_desc(3'd1, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        settle();
        chk("t5_nwr",  wlog_d.size(), 4);
        chk("t5_a3",   log_a(3), 3);
        chk("t5_ovf",  overflow, 1'b1);
        chk("t5_done", done_cnt, 1);
        chk("t5_wcnt", word_cnt, 4);

        // reset in the middle of a session
        open_session();
        send(3'd1, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd7, 1'b0);
        set_desc(3'd1, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd9, 1'b0);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("t6_we",    imem_we,    1'b0);
        chk("t6_ready", in_ready,   1'b0);
        chk("t6_wcnt",  word_cnt,   0);
        chk("t6_addr",  imem_addr,  BASE);
        chk("t6_wdata", imem_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6_nwr", wlog_d.size(), 1);

        // out-of-range addi immediate
        open_session();
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
        settle();
`ifdef INST_ENC_RANGE_CHECK_EN
        chk("t7_nwr", wlog_d.size(), 0);
        chk("t7_err", err_cnt, 8'd1);
`else
        chk("t7_nwr",  wlog_d.size(), 1);
        chk("t7_data", log_d(0), 32'h00000093);
        chk("t7_err",  err_cnt, 8'd0);
`endif
        chk("t7_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Encoder counterpart to the main-decoder opcode table. Takes decoded instruction descriptors (class, register indices, funct fields, immediate) and packs them into RV32I instruction words.
- Writes the packed words into instruction memory at sequential word addresses.
- Used by the bench and boot path to load programs without hand-assembled hex.
- Covers the same opcode set the control decoder recognises: R, I-ALU, LOAD, STORE, BRANCH, LUI, JAL.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, maximum words per load session (must be ≤ 2^ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; opens a load session.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_last  in  1  qualifies the final descriptor of the session.
- op_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=LUI, 6=JAL, 7=illegal.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R; I-ALU shifts).
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate, byte offset / value, sign-extended form.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle session-complete pulse.
- overflow  out  1  sticky; session hit DEPTH before in_last.
- err_cnt  out  8  rejected descriptors this session, saturating at 255.
- word_cnt  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready, imem_we, done, overflow = 0; imem_addr=BASE_ADDR; imem_wdata=0; err_cnt=0; word_cnt=0. Reset mid-session aborts it; no write is issued after reset.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start → LOAD. On entry: imem_addr pointer=BASE_ADDR; word_cnt, err_cnt, overflow cleared.
- LOAD:
  - in_ready = (word_cnt < DEPTH).
  - Accept occurs on in_valid & in_ready. The word is encoded combinationally and registered.
  - Next cycle: imem_we=1 for exactly one cycle, with imem_addr/imem_wdata holding that word. Latency is 1 cycle.
  - Pointer increments after each write, wrapping modulo 2^ADDR_W. word_cnt increments.
  - A descriptor may be accepted every cycle (back-to-back, one write per cycle).
  - Accepted with in_last → DONE.
  - word_cnt reaching DEPTH without in_last → overflow=1, → DONE.
  - start while in LOAD is ignored.
- DONE: done=1 for one cycle, then → IDLE. The final write's imem_we coincides with the DONE cycle.
- Illegal descriptor (op_class=7, or rejected by the optional check):
  - Accepted, but no write.
  - Pointer and word_cnt unchanged.
  - err_cnt+1, saturating.
  - in_last is still honoured.
- Encoding (bit concatenations, MSB first):
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - I-ALU: imm[11:0]|rs1|funct3|rd|0010011. For funct3=001/101 use funct7|imm[4:0] in [31:20].
  - LOAD: imm[11:0]|rs1|funct3|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - LUI: imm[31:12]|rd|0110111.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused input fields are ignored.

Optional Feature:
- Macro: INST_ENC_RANGE_CHECK_EN.
- Defined: a descriptor is treated as illegal when any of the following holds:
  - I-ALU/LOAD/STORE imm is outside [-2048, 2047].
  - BRANCH imm is outside [-4096, 4094] or imm[0]=1.
  - JAL imm is outside [-2^20, 2^20-2] or imm[0]=1.
  - LUI imm[11:0] ≠ 0.
- Undefined: no range checks; out-of-range immediates are silently truncated per the encoding slices.

Test Plan:
- start; R rd=3 rs1=1 rs2=2 f3=0 f7=0 (add), in_last=1 → 1 cycle later imem_we=1, addr=0, wdata=0x002081B3; done pulses; word_cnt=1.
- Back-to-back, no gaps:
  - I-ALU addi rd=1 imm=5 → 0x00500093 @0.
  - LOAD rd=4 rs1=2 f3=2 imm=-4 → 0xFFC12203 @1.
  - STORE rs1=1 rs2=2 f3=2 imm=8 → 0x0020A423 @2.
  - Expect three consecutive imem_we cycles.
- LUI rd=5 imm=0x12345000 → 0x123452B7. JAL rd=1 imm=8 → 0x008000EF. BRANCH beq rs1=0 rs2=0 imm=-4 → 0xFE000EE3.
- op_class=7 between two legal words → err_cnt=1; the legal words land at consecutive addresses 0 and 1.
- DEPTH=4, six descriptors with no in_last → 4 writes, in_ready drops, overflow=1, done pulses. Assert rst_n=0 mid-session → all outputs at reset values next cycle, with no further writes.
- With INST_ENC_RANGE_CHECK_EN: addi imm=4096 → rejected, err_cnt=1. Without it: written as 0x00000093.
